// File: rtl/mips_pkg.sv
// Shared MIPS definitions.
// Holds the R-type funct codes used by the main controller, the ALU decoder
// and the multiply/divide sequencer, plus the sequencer's state encoding.
package mips_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_ctrl.sv
// Multicycle multiply/divide sequencer owning the HI/LO register pair.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring), one bit per clock,
// on a shared 2*WIDTH accumulator and one WIDTH-bit adder/subtractor.
// MTHI/MTLO write HI/LO directly; MFHI/MFLO read combinationally via result.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, funct    command strobe and R-type funct field
//   srca, srcb      rs / rt operand values
//   busy, done      op in flight / one-cycle completion pulse
//   hi, lo          HI and LO registers
//   result          hi for MFHI, lo for MFLO, else 0
//
// state  | meaning
// S_IDLE | waiting for start; services MTHI/MTLO
// S_MUL  | one shift-add step per cycle, WIDTH cycles
// S_DIV  | one restoring-divide step per cycle, WIDTH cycles
// S_FIX  | apply result signs and write HI/LO
// S_DONE | done pulse, start ignored
module muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    muldiv_state_t state, state_nxt;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    function automatic logic [2*WIDTH-1:0] negate_if(input logic [2*WIDTH-1:0] v,
                                                     input logic n);
        return n ? -v : v;
    endfunction

    // Operand decode at issue
    logic             op_mul, op_div, op_signed, sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign op_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    assign op_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    assign op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign sign_a    = op_signed & srca[WIDTH-1];
    assign sign_b    = op_signed & srcb[WIDTH-1];
    assign abs_a     = sign_a ? -srca : srca;
    assign abs_b     = sign_b ? -srcb : srcb;

    // Shared adder. For divide it subtracts the divisor from the low WIDTH
    // bits of the shifted remainder; the bit shifted out of the top counts as
    // an extra 2^WIDTH, so the trial result is non-negative if that bit is set
    // or the subtraction did not borrow (carry out set).
    logic [WIDTH-1:0] add_a, add_b;
    logic [WIDTH:0]   sum;
    logic             div_ok;

    assign add_a  = is_div ? acc[2*WIDTH-2:WIDTH-1] : acc[2*WIDTH-1:WIDTH];
    assign add_b  = is_div ? ~opb : (acc[0] ? opb : '0);
    assign sum    = ({1'b0, add_a} + {1'b0, add_b}) + (WIDTH+1)'(is_div);
    assign div_ok = acc[2*WIDTH-1] | sum[WIDTH];

    logic [2*WIDTH-1:0] prod_fix, quot_fix, rem_fix;

    assign prod_fix = negate_if(acc, neg_q);
    assign quot_fix = negate_if({{WIDTH{1'b0}}, acc[WIDTH-1:0]}, neg_q);
    assign rem_fix  = negate_if({{WIDTH{1'b0}}, acc[2*WIDTH-1:WIDTH]}, neg_r);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && op_mul)      state_nxt = S_MUL;
                else if (start && op_div) state_nxt = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (funct == FUNCT_MTHI) hi <= srca;
                        if (funct == FUNCT_MTLO) lo <= srca;
                        if (op_mul || op_div) begin
                            // multiply: multiplier in acc low, multiplicand in opb
                            // divide:   dividend in acc low, divisor in opb
                            acc    <= {{WIDTH{1'b0}}, (op_mul ? abs_b : abs_a)};
                            opb    <= op_mul ? abs_a : abs_b;
                            is_div <= op_div;
                            neg_q  <= sign_a ^ sign_b;
                            neg_r  <= sign_a;
                            cnt    <= '0;
                        end
                    end
                end
                S_MUL: begin
                    acc <= {sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    if (div_ok) acc <= {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else        acc <= {acc[2*WIDTH-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (is_div) begin
                        lo <= quot_fix[WIDTH-1:0];
                        hi <= rem_fix[WIDTH-1:0];
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    assign done = (state == S_DONE);

    always_comb begin
        result = '0;
        if (funct == FUNCT_MFHI)      result = hi;
        else if (funct == FUNCT_MFLO) result = lo;
    end

endmodule
